// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Two-port arbiter and sequencer in front of the 16-bit data memory.
//   Port 0 is the CPU load/store unit and port 1 is the DMA/peripheral master.
//   Each cycle one request wins. Its address, direction and data go into a
//   slot register, and the memory access happens in the following cycle.
//   Read data is registered at the end of the access cycle and returned to
//   the port that issued it. Back-to-back grants give one access per cycle.
//
// Ports
//   CLK, RST                  clock (rising edge), async active-high reset
//   REQ_x/WR_x/ADDR_x/WDATA_x request from port x (held until GNT_x)
//   GNT_x                     combinational pulse, request accepted this cycle
//   RVALID_x/RDATA_x          read response, two cycles after the grant
//   LOCK_1                    port 1 asks to keep the grant for its next beat
//   MEM_ADDR/MEM_WR/MEM_DIN   memory command, driven from the slot registers
//   MEM_DOUT                  combinational memory read data
//   BUSY                      the access slot is occupied this cycle
module dmem_arbiter #(
  parameter int MAX_BURST = 8,
  parameter int AW        = 16,
  parameter int DW        = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          REQ_0,
  input  logic          WR_0,
  input  logic [AW-1:0] ADDR_0,
  input  logic [DW-1:0] WDATA_0,
  output logic          GNT_0,
  output logic          RVALID_0,
  output logic [DW-1:0] RDATA_0,
  input  logic          REQ_1,
  input  logic          WR_1,
  input  logic [AW-1:0] ADDR_1,
  input  logic [DW-1:0] WDATA_1,
  output logic          GNT_1,
  output logic          RVALID_1,
  output logic [DW-1:0] RDATA_1,
  input  logic          LOCK_1,
  output logic [AW-1:0] MEM_ADDR,
  output logic          MEM_WR,
  output logic [DW-1:0] MEM_DIN,
  input  logic [DW-1:0] MEM_DOUT,
  output logic          BUSY
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

  state_t        state_q, state_d;
  logic          rr_last_q, rr_last_d;
  logic [3:0]    burst_cnt_q, burst_cnt_d;
  logic          slot_wr_q, slot_wr_d;
  logic [AW-1:0] slot_addr_q, slot_addr_d;
  logic [DW-1:0] slot_wdata_q, slot_wdata_d;
  logic          rvalid0_q, rvalid0_d;
  logic          rvalid1_q, rvalid1_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic          lock_hold;

  // state_q is the owner of the slot this cycle. That is also last cycle's
  // winner, so it tells us whether the previous grant went to port 1.
  assign lock_hold = (state_q == OWN1) && LOCK_1 && (burst_cnt_q < MAX_CNT);

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state is this cycle's arbitration winner, plus the bookkeeping that
  // follows from it (round-robin pointer, burst count, slot capture, read return).
  always_comb begin
    state_d = IDLE;
    if (REQ_0 && REQ_1)  state_d = (lock_hold || !rr_last_q) ? OWN1 : OWN0;
    else if (REQ_0)      state_d = OWN0;
    else if (REQ_1)      state_d = OWN1;

    rr_last_d = rr_last_q;
    if (state_d == OWN0) rr_last_d = 1'b0;
    if (state_d == OWN1) rr_last_d = 1'b1;

    // The count saturates so that a lone port 1 can keep streaming while
    // port 0 is still forced in as soon as it shows up.
    burst_cnt_d = 4'd0;
    if (state_d == OWN1)
      burst_cnt_d = (burst_cnt_q == MAX_CNT) ? burst_cnt_q : burst_cnt_q + 4'd1;

    slot_wr_d    = 1'b0;
    slot_addr_d  = slot_addr_q;
    slot_wdata_d = slot_wdata_q;
    if (state_d == OWN0) begin
      slot_wr_d    = WR_0;
      slot_addr_d  = ADDR_0;
      slot_wdata_d = WDATA_0;
    end else if (state_d == OWN1) begin
      slot_wr_d    = WR_1;
      slot_addr_d  = ADDR_1;
      slot_wdata_d = WDATA_1;
    end

    // Only one owner per slot, so the two RVALIDs can never be high together.
    rvalid0_d = (state_q == OWN0) && !slot_wr_q;
    rvalid1_d = (state_q == OWN1) && !slot_wr_q;
    rdata0_d  = rvalid0_d ? MEM_DOUT : rdata0_q;
    rdata1_d  = rvalid1_d ? MEM_DOUT : rdata1_q;
  end

  // Datapath and arbitration registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rr_last_q    <= 1'b1;
      burst_cnt_q  <= 4'd0;
      slot_wr_q    <= 1'b0;
      slot_addr_q  <= '0;
      slot_wdata_q <= '0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      rr_last_q    <= rr_last_d;
      burst_cnt_q  <= burst_cnt_d;
      slot_wr_q    <= slot_wr_d;
      slot_addr_q  <= slot_addr_d;
      slot_wdata_q <= slot_wdata_d;
      rvalid0_q    <= rvalid0_d;
      rvalid1_q    <= rvalid1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  // Outputs. The grants are gated by RST so that they drop immediately.
  always_comb begin
    GNT_0    = !RST && (state_d == OWN0);
    GNT_1    = !RST && (state_d == OWN1);
    BUSY     = (state_q != IDLE);
    MEM_WR   = slot_wr_q && (state_q != IDLE);
    MEM_ADDR = slot_addr_q;
    MEM_DIN  = slot_wdata_q;
    RVALID_0 = rvalid0_q;
    RVALID_1 = rvalid1_q;
    RDATA_0  = rdata0_q;
    RDATA_1  = rdata1_q;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter, using a behavioural memory model.
// Memory that has never been written reads back as the inverted address.
module tb_dmem_arbiter;

  logic        CLK, RST;
  logic        REQ_0, WR_0, REQ_1, WR_1, LOCK_1;
  logic [15:0] ADDR_0, WDATA_0, ADDR_1, WDATA_1;
  logic        GNT_0, GNT_1, RVALID_0, RVALID_1, MEM_WR, BUSY;
  logic [15:0] RDATA_0, RDATA_1, MEM_ADDR, MEM_DIN, MEM_DOUT;

  int vectors = 0;
  int miscompares = 0;

  bit [15:0] memData [65536];
  bit        memWritten [65536];

  dmem_arbiter #(.MAX_BURST(8), .AW(16), .DW(16)) dut (
    .CLK(CLK), .RST(RST),
    .REQ_0(REQ_0), .WR_0(WR_0), .ADDR_0(ADDR_0), .WDATA_0(WDATA_0),
    .GNT_0(GNT_0), .RVALID_0(RVALID_0), .RDATA_0(RDATA_0),
    .REQ_1(REQ_1), .WR_1(WR_1), .ADDR_1(ADDR_1), .WDATA_1(WDATA_1),
    .GNT_1(GNT_1), .RVALID_1(RVALID_1), .RDATA_1(RDATA_1),
    .LOCK_1(LOCK_1),
    .MEM_ADDR(MEM_ADDR), .MEM_WR(MEM_WR), .MEM_DIN(MEM_DIN),
    .MEM_DOUT(MEM_DOUT), .BUSY(BUSY)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Memory model: combinational read, write on the rising edge.
  assign MEM_DOUT = memWritten[MEM_ADDR] ? memData[MEM_ADDR] : ~MEM_ADDR;

  always @(posedge CLK) begin
    if (MEM_WR) begin
      memData[MEM_ADDR]    <= MEM_DIN;
      memWritten[MEM_ADDR] <= 1'b1;
    end
  end

  // Watchdog: the bench should never get near this limit.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic r0, input logic w0, input logic [15:0] a0,
                               input logic [15:0] d0, input logic r1, input logic w1,
                               input logic [15:0] a1, input logic [15:0] d1,
                               input logic lk);
    REQ_0 = r0; WR_0 = w0; ADDR_0 = a0; WDATA_0 = d0;
    REQ_1 = r1; WR_1 = w1; ADDR_1 = a1; WDATA_1 = d1;
    LOCK_1 = lk;
  endtask

  task automatic idleInputs();
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
  endtask

  task automatic stepCycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic doReset();
    RST = 1'b1;
    idleInputs();
    stepCycle();
    stepCycle();
    RST = 1'b0;
  endtask

  logic [15:0] pageAddr [3];
  logic [15:0] pageData [3];

  initial begin
    pageAddr[0] = 16'h0FFF; pageData[0] = 16'hA001;
    pageAddr[1] = 16'h1000; pageData[1] = 16'hB002;
    pageAddr[2] = 16'hF000; pageData[2] = 16'hC003;

    // Reset: a request made while reset is high must not be granted.
    RST = 1'b1;
    applyStimulus(1'b1, 1'b0, 16'h0001, 16'h0, 1'b1, 1'b0, 16'h0002, 16'h0, 1'b0);
    #2;
    checkOutput("rst_gnt0", GNT_0, 1'b0);
    checkOutput("rst_gnt1", GNT_1, 1'b0);
    checkOutput("rst_busy", BUSY, 1'b0);
    checkOutput("rst_memwr", MEM_WR, 1'b0);
    checkOutput("rst_rvalid", {RVALID_0, RVALID_1}, 2'b00);
    checkOutput("rst_rdata", {RDATA_0, RDATA_1}, 32'h0);
    doReset();

    // Write 1234=BEEF and then read it back from port 0.
    applyStimulus(1'b1, 1'b1, 16'h1234, 16'hBEEF, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    @(negedge CLK);
    checkOutput("t1_gnt_wr", GNT_0, 1'b1);
    checkOutput("t1_memwr_a", MEM_WR, 1'b0);
    stepCycle();
    applyStimulus(1'b1, 1'b0, 16'h1234, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    @(negedge CLK);
    checkOutput("t1_gnt_rd", GNT_0, 1'b1);
    checkOutput("t1_memwr_b", MEM_WR, 1'b1);
    checkOutput("t1_memaddr", MEM_ADDR, 16'h1234);
    checkOutput("t1_memdin", MEM_DIN, 16'hBEEF);
    stepCycle();
    idleInputs();
    @(negedge CLK);
    checkOutput("t1_memwr_c", MEM_WR, 1'b0);
    checkOutput("t1_busy_c", BUSY, 1'b1);
    checkOutput("t1_rvalid_c", RVALID_0, 1'b0);
    stepCycle();
    @(negedge CLK);
    checkOutput("t1_rvalid_d", RVALID_0, 1'b1);
    checkOutput("t1_rdata_d", RDATA_0, 16'hBEEF);
    checkOutput("t1_rvalid1_d", RVALID_1, 1'b0);
    checkOutput("t1_busy_d", BUSY, 1'b0);
    stepCycle();
    @(negedge CLK);
    checkOutput("t1_rvalid_e", RVALID_0, 1'b0);
    checkOutput("t1_rdata_hold", RDATA_0, 16'hBEEF);

    // Both ports reading continuously without lock: grants alternate starting with port 0.
    doReset();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0, 1'b1, 1'b0, 16'h0020, 16'h0, 1'b0);
      @(negedge CLK);
      checkOutput($sformatf("t2_gnt0_%0d", i), GNT_0, (i % 2) == 0);
      checkOutput($sformatf("t2_gnt1_%0d", i), GNT_1, (i % 2) == 1);
      checkOutput($sformatf("t2_busy_%0d", i), BUSY, i >= 1);
      checkOutput($sformatf("t2_rv0_%0d", i), RVALID_0, (i >= 2) && ((i % 2) == 0));
      checkOutput($sformatf("t2_rv1_%0d", i), RVALID_1, (i >= 2) && ((i % 2) == 1));
      if (i >= 2 && (i % 2) == 0) checkOutput($sformatf("t2_rd0_%0d", i), RDATA_0, 16'hFFEF);
      if (i >= 2 && (i % 2) == 1) checkOutput($sformatf("t2_rd1_%0d", i), RDATA_1, 16'hFFDF);
      stepCycle();
    end

    // Locked burst: port 0 first, then 8 grants to port 1, then port 0, then port 1 again.
    doReset();
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0, 1'b1, 1'b0, 16'h0020, 16'h0, 1'b1);
      @(negedge CLK);
      checkOutput($sformatf("t3_gnt0_%0d", i), GNT_0, (i == 0) || (i == 9));
      checkOutput($sformatf("t3_gnt1_%0d", i), GNT_1, (i >= 1 && i <= 8) || (i >= 10));
      stepCycle();
    end

    // Port 1 writes across page boundaries, then port 0 reads the data back.
    doReset();
    for (int i = 0; i < 8; i++) begin
      if (i < 3)
        applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, pageAddr[i], pageData[i], 1'b0);
      else if (i < 6)
        applyStimulus(1'b1, 1'b0, pageAddr[i-3], 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      else
        idleInputs();
      @(negedge CLK);
      if (i < 3) checkOutput($sformatf("t4_gnt1_%0d", i), GNT_1, 1'b1);
      else if (i < 6) checkOutput($sformatf("t4_gnt0_%0d", i), GNT_0, 1'b1);
      if (i >= 1 && i <= 3) begin
        checkOutput($sformatf("t4_memwr_%0d", i), MEM_WR, 1'b1);
        checkOutput($sformatf("t4_memaddr_%0d", i), MEM_ADDR, pageAddr[i-1]);
      end
      checkOutput($sformatf("t4_rv0_%0d", i), RVALID_0, i >= 5);
      if (i >= 5) checkOutput($sformatf("t4_rd0_%0d", i), RDATA_0, pageData[i-5]);
      stepCycle();
    end

    // Reset in the middle of a write access, with a read still pending.
    doReset();
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0040, 16'h0, 1'b1);
    @(negedge CLK);
    checkOutput("t5_gnt_p", GNT_1, 1'b1);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 16'h0041, 16'h5555, 1'b1);
    @(negedge CLK);
    checkOutput("t5_gnt_q", GNT_1, 1'b1);
    checkOutput("t5_memwr_q", MEM_WR, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0040, 16'h0, 1'b1);
    @(negedge CLK);
    checkOutput("t5_gnt_r", GNT_1, 1'b1);
    checkOutput("t5_memwr_r", MEM_WR, 1'b1);
    checkOutput("t5_rv1_r", RVALID_1, 1'b1);
    checkOutput("t5_rd1_r", RDATA_1, 16'hFFBF);
    #1;
    RST = 1'b1;
    #1;
    checkOutput("t5_async_memwr", MEM_WR, 1'b0);
    checkOutput("t5_async_gnt", {GNT_0, GNT_1}, 2'b00);
    checkOutput("t5_async_rv", {RVALID_0, RVALID_1}, 2'b00);
    checkOutput("t5_async_busy", BUSY, 1'b0);
    stepCycle();
    idleInputs();
    stepCycle();
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checkOutput($sformatf("t5_norv_%0d", i), {RVALID_0, RVALID_1}, 2'b00);
      stepCycle();
    end
    applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0, 1'b1, 1'b0, 16'h0020, 16'h0, 1'b0);
    @(negedge CLK);
    checkOutput("t5_tie_gnt0", GNT_0, 1'b1);
    checkOutput("t5_tie_gnt1", GNT_1, 1'b0);
    stepCycle();

    // Port 0 drops its request while port 1 holds a locked burst.
    doReset();
    for (int i = 0; i < 8; i++) begin
      applyStimulus((i >= 1 && i <= 3), 1'b1, 16'h0777, 16'hDEAD,
                    1'b1, 1'b0, 16'h0030, 16'h0, 1'b1);
      @(negedge CLK);
      checkOutput($sformatf("t6_gnt0_%0d", i), GNT_0, 1'b0);
      checkOutput($sformatf("t6_gnt1_%0d", i), GNT_1, 1'b1);
      checkOutput($sformatf("t6_addr_%0d", i), MEM_ADDR == 16'h0777, 1'b0);
      stepCycle();
    end
    idleInputs();
    stepCycle();
    stepCycle();
    checkOutput("t6_no_write", memWritten[16'h0777], 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer for the 16-bit data memory.
- Port 0 is the CPU load/store unit; port 1 is the DMA/peripheral master.
- It owns the memory's ADDR/MEM_WR/DATA_IN/DATA_OUT interface.
- Sustains one access per cycle, arbitrates round-robin, and lets port 1 lock bounded bursts.
- Returns registered read data to the issuing port.

Parameters:
- MAX_BURST, 8, maximum consecutive port-1 grants under LOCK_1 while REQ_0 is pending (1..15).
- AW, 16, address width (the memory is fully decoded by ADDR[15:12] page, ADDR[11:0] offset).
- DW, 16, data width.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- REQ_0  input  1  port 0 access request; level, held until GNT_0.
- WR_0  input  1  port 0: 1 = write, 0 = read.
- ADDR_0  input  AW  port 0 address.
- WDATA_0  input  DW  port 0 write data.
- GNT_0  output  1  one-cycle pulse: port 0 request accepted.
- RVALID_0  output  1  one-cycle pulse: RDATA_0 valid.
- RDATA_0  output  DW  port 0 read data.
- REQ_1, WR_1, ADDR_1, WDATA_1, GNT_1, RVALID_1, RDATA_1: same as port 0, for port 1.
- LOCK_1  input  1  port 1 requests the grant be held for the next beat.
- MEM_ADDR  output  AW  to memory ADDR.
- MEM_WR  output  1  to memory MEM_WR.
- MEM_DIN  output  DW  to memory DATA_IN.
- MEM_DOUT  input  DW  from memory DATA_OUT (combinational read).
- BUSY  output  1  an access slot is occupied this cycle.

Behaviour:
- Reset (async, immediate): all outputs 0, FSM to IDLE, rr_last=1 (port 0 wins first tie), burst_cnt=0, pending read dropped.
  - MEM_WR must fall with RST even mid-write.
- Request rules:
  - Requester holds REQ_x/WR_x/ADDR_x/WDATA_x stable until sampling GNT_x=1.
  - Dropping REQ before the grant is legal; no grant is then issued.
- Pipeline (grant at edge N):
  - Cycle N: GNT_x=1; the request is latched into slot registers.
  - Cycle N+1: MEM_ADDR/MEM_WR/MEM_DIN driven from the slot registers, stable the whole cycle, BUSY=1.
  - For a read, MEM_DOUT is captured at the end of N+1; RDATA_x/RVALID_x are valid in cycle N+2.
  - Write has no response.
  - Read latency is 2 cycles from grant.
  - Back-to-back grants are allowed every cycle; throughput is 1 access/cycle.
- FSM, slot owner: IDLE, OWN0, OWN1.
  - Each edge, the next state is the winner of this cycle's arbitration, or IDLE if there are no requests.
  - MEM_WR=0 whenever the slot is IDLE.
- Arbitration, evaluated each cycle:
  - Only one REQ: that port wins.
  - Both REQ: the port not equal to rr_last wins, unless the lock rule applies.
  - Lock rule: if the previous grant was port 1, LOCK_1=1 and burst_cnt<MAX_BURST, port 1 wins.
  - Winner updates rr_last.
- Burst counter:
  - burst_cnt increments on each consecutive port-1 grant.
  - Clears on any port-0 grant or any idle cycle.
  - Saturates at MAX_BURST, which forces port 0 to win if REQ_0=1.
  - If REQ_0=0, port 1 continues and burst_cnt holds at MAX_BURST.
- Read data outputs: RDATA_x holds its last value between RVALID pulses; RVALID_0 and RVALID_1 are never both 1.
- Hazard: a read granted the cycle after a write to the same address returns the new data, because the write completes in cycle N+1 before the read's access cycle.
- Address arithmetic: none; addresses pass through unmodified, and page wrap is the memory's concern.

Test Plan:
- Reset, then REQ_0 write ADDR_0=16'h1234, WDATA_0=16'hBEEF; next cycle read 16'h1234 → GNT_0 pulses on both; RVALID_0=1 with RDATA_0=16'hBEEF two cycles after the read grant; MEM_WR high for exactly 1 cycle.
- REQ_0 and REQ_1 held continuously with reads, LOCK_1=0 → grants alternate 0,1,0,1 starting with port 0; one access per cycle; RVALID alternates accordingly.
- REQ_1 with LOCK_1=1 and REQ_0 asserted, MAX_BURST=8 → exactly 8 consecutive GNT_1, then GNT_0, then port 1 resumes.
- Writes across pages 16'h0FFF, 16'h1000, 16'hF000 from port 1 with distinct data, then readback from port 0 → each address returns its own data, with no aliasing.
- RST asserted while MEM_WR=1 mid-burst → MEM_WR, GNT_x, RVALID_x and BUSY go 0 asynchronously; after release, the pending read produces no RVALID, and the first tie goes to port 0.
- Port drops REQ_0 before being granted while port 1 is locked → no GNT_0 is ever issued and no memory access occurs for port 0.
